// File: rtl/sap_ctrl_pkg.sv
// Shared types for the SAP control sequencer: opcodes, FSM states and the 16-bit control word.
// The optional single-step feature of the sequencer is enabled with CTRL_STEP_EN.
package sap_ctrl_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned T_STATES_DEF = 6;
  localparam int unsigned TW           = 3;
  localparam int unsigned OP_W         = 4;
  localparam int unsigned CTRL_W       = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_t;

  // Control word, MSB first; fields ending in _ are active-low chip enables.
  typedef struct packed {
    logic rsvd;
    logic pc_out_;
    logic pc_load_;
    logic pc_inc;
    logic mar_load_;
    logic ram_cs_;
    logic ram_we_;
    logic ir_load_;
    logic ir_out_;
    logic a_load_;
    logic a_out_;
    logic b_load_;
    logic alu_out_;
    logic alu_sub;
    logic flag_load;
    logic out_load_;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    rsvd:      1'b0,
    pc_out_:   1'b1,
    pc_load_:  1'b1,
    pc_inc:    1'b0,
    mar_load_: 1'b1,
    ram_cs_:   1'b1,
    ram_we_:   1'b1,
    ir_load_:  1'b1,
    ir_out_:   1'b1,
    a_load_:   1'b1,
    a_out_:    1'b1,
    b_load_:   1'b1,
    alu_out_:  1'b1,
    alu_sub:   1'b0,
    flag_load: 1'b0,
    out_load_: 1'b1
  };

  // Word shown while waiting for a step: bus drivers kept, every state-changing strobe released.
  function automatic ctrl_t hold_strobes(input ctrl_t c);
    ctrl_t h;
    h           = c;
    h.pc_load_  = 1'b1;
    h.pc_inc    = 1'b0;
    h.mar_load_ = 1'b1;
    h.ir_load_  = 1'b1;
    h.a_load_   = 1'b1;
    h.b_load_   = 1'b1;
    h.out_load_ = 1'b1;
    h.flag_load = 1'b0;
    // a write step must not turn into a RAM read that fights a_out_
    if (!c.ram_we_) h.ram_cs_ = 1'b1;
    h.ram_we_   = 1'b1;
    return h;
  endfunction

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational microcode ROM: (tstate, opcode, flags) -> control word plus end-of-instruction flag.
module sap_ctrl_decode
  import sap_ctrl_pkg::*;
(
  input  logic [TW-1:0]   tstate,
  input  logic [OP_W-1:0] opcode,
  input  logic            flag_c,
  input  logic            flag_z,
  output ctrl_t           ctrl,
  output logic            last_step
);

  opcode_t op;
  assign op = opcode_t'(opcode);

  always_comb begin
    ctrl      = CTRL_IDLE;
    last_step = 1'b0;
    case (tstate)
      3'd0: begin
        ctrl.pc_out_   = 1'b0;
        ctrl.mar_load_ = 1'b0;
      end
      3'd1: begin
        ctrl.ram_cs_  = 1'b0;
        ctrl.ir_load_ = 1'b0;
        ctrl.pc_inc   = 1'b1;
      end
      default: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            // memory-operand group: T2 always latches the address field into MAR
            case (tstate)
              3'd2: begin
                ctrl.ir_out_   = 1'b0;
                ctrl.mar_load_ = 1'b0;
              end
              3'd3: begin
                if (op == OP_STA) begin
                  ctrl.a_out_  = 1'b0;
                  ctrl.ram_cs_ = 1'b0;
                  ctrl.ram_we_ = 1'b0;
                  last_step    = 1'b1;
                end else if (op == OP_LDA) begin
                  ctrl.ram_cs_ = 1'b0;
                  ctrl.a_load_ = 1'b0;
                  last_step    = 1'b1;
                end else begin
                  ctrl.ram_cs_  = 1'b0;
                  ctrl.b_load_  = 1'b0;
                end
              end
              3'd4: begin
                if (op == OP_ADD || op == OP_SUB) begin
                  ctrl.alu_out_  = 1'b0;
                  ctrl.a_load_   = 1'b0;
                  ctrl.flag_load = 1'b1;
                  ctrl.alu_sub   = (op == OP_SUB);
                  last_step      = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_LDI: begin
            if (tstate == 3'd2) begin
              ctrl.ir_out_ = 1'b0;
              ctrl.a_load_ = 1'b0;
              last_step    = 1'b1;
            end
          end
          OP_JMP, OP_JC, OP_JZ: begin
            if (tstate == 3'd2) begin
              if (op == OP_JMP || (op == OP_JC && flag_c) || (op == OP_JZ && flag_z)) begin
                ctrl.ir_out_  = 1'b0;
                ctrl.pc_load_ = 1'b0;
              end
              last_step = 1'b1;
            end
          end
          OP_OUT: begin
            if (tstate == 3'd2) begin
              ctrl.a_out_    = 1'b0;
              ctrl.out_load_ = 1'b0;
              last_step      = 1'b1;
            end
          end
          default: begin
            // HLT and all unused opcodes spend one empty execute step
            if (tstate == 3'd2) last_step = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP microcode sequencer: T-state counter, IDLE/RUN/HALT FSM, C/Z flags and bus control word.
// Define CTRL_STEP_EN to add the single-step input (tstate advances only on step rising edges).
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter int unsigned N        = DATA_W,
  parameter int unsigned T_STATES = T_STATES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  input  logic [N-1:0]    alu_s,
  input  logic            alu_k,
`ifdef CTRL_STEP_EN
  input  logic            step,
`endif
  output ctrl_t           ctrl,
  output logic [TW-1:0]   tstate,
  output logic            halted,
  output logic            flag_c,
  output logic            flag_z
);

  fsm_t          state, state_nxt;
  logic [TW-1:0] tstate_nxt;
  ctrl_t         dec_ctrl;
  logic          last_step;
  logic          end_slot;
  logic          hlt_seen;
  logic          adv;

  sap_ctrl_decode u_decode (
    .tstate    (tstate),
    .opcode    (opcode),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .ctrl      (dec_ctrl),
    .last_step (last_step)
  );

`ifdef CTRL_STEP_EN
  logic [2:0] step_sync;

  // two-flop synchroniser plus one delayed copy for rising-edge detect
  always_ff @(posedge clk) begin
    if (reset) step_sync <= '0;
    else       step_sync <= {step_sync[1:0], step};
  end

  assign adv = step_sync[1] & ~step_sync[2];
`else
  assign adv = 1'b1;
`endif

  assign end_slot = last_step || (tstate == TW'(T_STATES - 1));
  assign hlt_seen = (opcode_t'(opcode) == OP_HLT) && (tstate == 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      tstate <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      tstate <= tstate_nxt;
      halted <= (state_nxt == HALT);
    end
  end

  always_comb begin
    state_nxt  = state;
    tstate_nxt = tstate;
    ctrl       = CTRL_IDLE;
    case (state)
      IDLE: begin
        tstate_nxt = '0;
        if (run) state_nxt = RUN;
      end
      RUN: begin
        ctrl = dec_ctrl;
        if (!adv) begin
          ctrl = hold_strobes(dec_ctrl);
        end else if (end_slot) begin
          // instruction boundary: the only place run and HLT are honoured
          tstate_nxt = '0;
          if (hlt_seen)  state_nxt = HALT;
          else if (!run) state_nxt = IDLE;
        end else begin
          tstate_nxt = TW'(tstate + 3'd1);
        end
      end
      HALT: begin
        tstate_nxt = '0;
      end
      default: begin
        state_nxt  = IDLE;
        tstate_nxt = '0;
      end
    endcase
    if (reset) ctrl = CTRL_IDLE;
  end

  // Flags capture the adder result only on the ALU write-back step.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (ctrl.flag_load) begin
      flag_c <= alu_k;
      flag_z <= (alu_s == '0);
    end
  end

  logic [4:0] bus_drv;
  assign bus_drv = {~ctrl.pc_out_, ~ctrl.ir_out_, ~ctrl.ram_cs_ & ctrl.ram_we_,
                    ~ctrl.a_out_, ~ctrl.alu_out_};

  a_one_bus_driver: assert property (@(posedge clk) disable iff (reset) $onehot0(bus_drv));

  a_we_single_cycle: assert property (@(posedge clk) disable iff (reset)
    !ctrl.ram_we_ |=> ctrl.ram_we_);

`ifndef CTRL_STEP_EN
  a_we_after_mar: assert property (@(posedge clk) disable iff (reset)
    !ctrl.ram_we_ |-> $past(!ctrl.mar_load_));
`endif

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: microcode walk table, corner sequences, random model.
`timescale 1ns/1ps
module tb_sap_control_sequencer;
  import sap_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset, run, alu_k;
  logic [3:0] opcode;
  logic [7:0] alu_s;
`ifdef CTRL_STEP_EN
  logic       step;
`endif
  ctrl_t      ctrl;
  logic [2:0] tstate;
  logic       halted, flag_c, flag_z;

  int total = 0;
  int bad   = 0;

  sap_control_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .opcode (opcode),
    .alu_s  (alu_s),
    .alu_k  (alu_k),
`ifdef CTRL_STEP_EN
    .step   (step),
`endif
    .ctrl   (ctrl),
    .tstate (tstate),
    .halted (halted),
    .flag_c (flag_c),
    .flag_z (flag_z)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // single-signal masks, positive sense: expected word = idle_w ^ (OR of asserted masks)
  logic [15:0] m_pco, m_marl, m_ram, m_we, m_irl, m_iro, m_al, m_ao, m_bl, m_alo, m_outl,
               m_pcl, m_inc, m_sub, m_fl, idle_w;

  task automatic init_masks();
    ctrl_t t;
    t = '0; t.pc_out_   = 1'b1; m_pco  = t;
    t = '0; t.mar_load_ = 1'b1; m_marl = t;
    t = '0; t.ram_cs_   = 1'b1; m_ram  = t;
    t = '0; t.ram_we_   = 1'b1; m_we   = t;
    t = '0; t.ir_load_  = 1'b1; m_irl  = t;
    t = '0; t.ir_out_   = 1'b1; m_iro  = t;
    t = '0; t.a_load_   = 1'b1; m_al   = t;
    t = '0; t.a_out_    = 1'b1; m_ao   = t;
    t = '0; t.b_load_   = 1'b1; m_bl   = t;
    t = '0; t.alu_out_  = 1'b1; m_alo  = t;
    t = '0; t.out_load_ = 1'b1; m_outl = t;
    t = '0; t.pc_load_  = 1'b1; m_pcl  = t;
    t = '0; t.pc_inc    = 1'b1; m_inc  = t;
    t = '0; t.alu_sub   = 1'b1; m_sub  = t;
    t = '0; t.flag_load = 1'b1; m_fl   = t;
    idle_w = m_pco | m_marl | m_ram | m_we | m_irl | m_iro | m_al | m_ao | m_bl | m_alo |
             m_outl | m_pcl;
  endtask

  typedef struct {
    logic [3:0]  op;
    int          len;
    logic [15:0] e2, e3, e4;
    logic [7:0]  s;
    logic        k, ec, ez;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input int len, input logic [15:0] e2,
                              input logic [15:0] e3, input logic [15:0] e4, input logic [7:0] s,
                              input logic k, input logic ec, input logic ez);
    vec_t v;
    v.op = op; v.len = len; v.e2 = e2; v.e3 = e3; v.e4 = e4;
    v.s = s; v.k = k; v.ec = ec; v.ez = ez;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // leave IDLE: after this the DUT sits in T0 of RUN
  task automatic start();
    run = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] e;
    opcode = v.op; alu_s = v.s; alu_k = v.k;
    for (int st = 0; st < v.len; st++) begin
      case (st)
        0:       e = m_pco | m_marl;
        1:       e = m_ram | m_irl | m_inc;
        2:       e = v.e2;
        3:       e = v.e3;
        default: e = v.e4;
      endcase
      @(negedge clk);
      chk($sformatf("vec%0d_t%0d_tstate", idx, st), 32'(tstate), 32'(st));
      chk($sformatf("vec%0d_t%0d_ctrl", idx, st), 32'(ctrl), 32'(idle_w ^ e));
      tick();
    end
    chk($sformatf("vec%0d_flag_c", idx), 32'(flag_c), 32'(v.ec));
    chk($sformatf("vec%0d_flag_z", idx), 32'(flag_z), 32'(v.ez));
  endtask

  vec_t vt[17];

  initial begin
    init_masks();
    reset = 1'b1; run = 1'b0; opcode = 4'h0; alu_s = 8'h00; alu_k = 1'b0;
`ifdef CTRL_STEP_EN
    step = 1'b0;
`endif
    tick(); tick();

    @(negedge clk);
    chk("reset_tstate", 32'(tstate), 32'd0);
    chk("reset_ctrl", 32'(ctrl), 32'(idle_w));
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_flag_c", 32'(flag_c), 32'd0);
    chk("reset_flag_z", 32'(flag_z), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", 32'(ctrl), 32'(idle_w));

`ifdef CTRL_STEP_EN
    begin
      int chg, lds;
      logic [2:0] prev;
      logic [15:0] w;
      opcode = 4'h5;
      tick();
      start();
      for (int p = 0; p < 5; p++) begin
        chg = 0; lds = 0; prev = tstate;
        step = 1'b1;
        for (int c = 0; c < 10; c++) begin
          if (c == 2) step = 1'b0;
          @(negedge clk);
          w = ctrl;
          if ((w & (m_marl | m_irl | m_al | m_bl | m_pcl | m_outl | m_we)) !=
              (idle_w & (m_marl | m_irl | m_al | m_bl | m_pcl | m_outl | m_we)) ||
              (w & (m_inc | m_fl)) != 16'h0)
            lds++;
          tick();
          if (tstate != prev) chg++;
          prev = tstate;
        end
        chk($sformatf("step%0d_advances", p), 32'(chg), 32'd1);
        chk($sformatf("step%0d_strobes", p), 32'(lds), 32'd1);
      end
    end
`else
    // microcode walk from reset: flags start clear, ALU inputs only matter on ALU steps
    vt[0]  = mk(4'h5, 3, m_iro | m_al,   16'h0,        16'h0, 8'hFF, 1'b1, 1'b0, 1'b0);
    vt[1]  = mk(4'h1, 4, m_iro | m_marl, m_ram | m_al, 16'h0, 8'hFF, 1'b1, 1'b0, 1'b0);
    vt[2]  = mk(4'h4, 4, m_iro | m_marl, m_ao | m_ram | m_we, 16'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[3]  = mk(4'h6, 3, m_iro | m_pcl,  16'h0,        16'h0, 8'hFF, 1'b1, 1'b0, 1'b0);
    vt[4]  = mk(4'h7, 3, 16'h0,          16'h0,        16'h0, 8'hFF, 1'b1, 1'b0, 1'b0);
    vt[5]  = mk(4'h8, 3, 16'h0,          16'h0,        16'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[6]  = mk(4'hE, 3, m_ao | m_outl,  16'h0,        16'h0, 8'hFF, 1'b1, 1'b0, 1'b0);
    vt[7]  = mk(4'h0, 3, 16'h0,          16'h0,        16'h0, 8'hFF, 1'b1, 1'b0, 1'b0);
    vt[8]  = mk(4'hA, 3, 16'h0,          16'h0,        16'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[9]  = mk(4'h2, 5, m_iro | m_marl, m_ram | m_bl, m_alo | m_al | m_fl, 8'h00, 1'b1, 1'b1, 1'b1);
    vt[10] = mk(4'h8, 3, m_iro | m_pcl,  16'h0,        16'h0, 8'h5A, 1'b0, 1'b1, 1'b1);
    vt[11] = mk(4'h7, 3, m_iro | m_pcl,  16'h0,        16'h0, 8'h5A, 1'b0, 1'b1, 1'b1);
    vt[12] = mk(4'h3, 5, m_iro | m_marl, m_ram | m_bl, m_alo | m_al | m_fl | m_sub, 8'h05, 1'b0,
                1'b0, 1'b0);
    vt[13] = mk(4'h7, 3, 16'h0,          16'h0,        16'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    vt[14] = mk(4'h2, 5, m_iro | m_marl, m_ram | m_bl, m_alo | m_al | m_fl, 8'h00, 1'b0, 1'b0, 1'b1);
    vt[15] = mk(4'h8, 3, m_iro | m_pcl,  16'h0,        16'h0, 8'hFF, 1'b1, 1'b0, 1'b1);
    vt[16] = mk(4'hF, 3, 16'h0,          16'h0,        16'h0, 8'hFF, 1'b1, 1'b0, 1'b1);
    tick();
    start();
    for (int i = 0; i < 17; i++) run_vec(vt[i], i);

    // HLT: frozen until reset, run ignored
    for (int c = 0; c < 4; c++) begin
      run = c[0];
      @(negedge clk);
      chk($sformatf("halt%0d_halted", c), 32'(halted), 32'd1);
      chk($sformatf("halt%0d_ctrl", c), 32'(ctrl), 32'(idle_w));
      chk($sformatf("halt%0d_tstate", c), 32'(tstate), 32'd0);
      tick();
    end
    do_reset();
    @(negedge clk);
    chk("halt_reset_halted", 32'(halted), 32'd0);
    chk("halt_reset_ctrl", 32'(ctrl), 32'(idle_w));

    // run dropped during fetch: LDA completes, then IDLE
    tick();
    opcode = 4'h1;
    start();
    run = 1'b0;
    for (int st = 0; st < 4; st++) begin
      @(negedge clk);
      chk($sformatf("stop_t%0d", st), 32'(tstate), 32'(st));
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("stop_idle%0d_ctrl", c), 32'(ctrl), 32'(idle_w));
      chk($sformatf("stop_idle%0d_tstate", c), 32'(tstate), 32'd0);
      tick();
    end

    // reset in ADD T3: no write-back, IDLE next, then fetch resumes
    opcode = 4'h2; alu_s = 8'h00; alu_k = 1'b1;
    start();
    tick(); tick(); tick();
    @(negedge clk);
    chk("mid_pre_tstate", 32'(tstate), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_idle_ctrl", 32'(ctrl), 32'(idle_w));
    chk("mid_idle_tstate", 32'(tstate), 32'd0);
    chk("mid_flag_c", 32'(flag_c), 32'd0);
    tick();
    @(negedge clk);
    chk("mid_resume_ctrl", 32'(ctrl), 32'(idle_w ^ (m_pco | m_marl)));
    tick();

    // random programme against an instruction-level model
    do_reset();
    start();
    begin
      logic mc, mz;
      mc = 1'b0; mz = 1'b0;
      for (int n = 0; n < 80; n++) begin
        logic [3:0] op;
        int len, npl, nwe, nal, epl, ewe, eal;
        op  = 4'($urandom_range(0, 15));
        len = (op == 4'h1 || op == 4'h4) ? 4 : (op == 4'h2 || op == 4'h3) ? 5 : 3;
        epl = (op == 4'h6 || (op == 4'h7 && mc) || (op == 4'h8 && mz)) ? 1 : 0;
        ewe = (op == 4'h4) ? 1 : 0;
        eal = (op inside {4'h1, 4'h2, 4'h3, 4'h5}) ? 1 : 0;
        npl = 0; nwe = 0; nal = 0;
        opcode = op;
        for (int st = 0; st < len; st++) begin
          alu_s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
          alu_k = 1'($urandom);
          @(negedge clk);
          chk("rnd_tstate", 32'(tstate), 32'(st));
          if (!ctrl.pc_load_) npl++;
          if (!ctrl.ram_we_)  nwe++;
          if (!ctrl.a_load_)  nal++;
          if (st == 4) begin
            mc = alu_k;
            mz = (alu_s == 8'h00);
          end
          tick();
        end
        chk($sformatf("rnd%0d_op%0h_pc_load", n, op), 32'(npl), 32'(epl));
        chk($sformatf("rnd%0d_op%0h_ram_we", n, op), 32'(nwe), 32'(ewe));
        chk($sformatf("rnd%0d_op%0h_a_load", n, op), 32'(nal), 32'(eal));
        chk($sformatf("rnd%0d_flag_c", n), 32'(flag_c), 32'(mc));
        chk($sformatf("rnd%0d_flag_z", n), 32'(flag_z), 32'(mz));
        chk($sformatf("rnd%0d_halted", n), 32'(halted), 32'(op == 4'hF));
        if (op == 4'hF) begin
          do_reset();
          start();
          mc = 1'b0; mz = 1'b0;
        end else begin
          chk($sformatf("rnd%0d_wrap", n), 32'(tstate), 32'd0);
        end
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
